// File: rtl/int_ram_ctrl.sv
// int_ram_ctrl: ping-pong controller for the two-bank intrinsic-message RAM.
// A channel loader streams one frame of LLRs into the free bank while the
// decoder core reads the other bank. Banks are handed over automatically when
// a frame finishes loading and when the decoder finishes with a frame.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ld_valid/ld_ready/ld_data       loader stream (valid/ready handshake)
//   dec_frame_avail   a FULL frame is waiting at the read bank
//   dec_start         decoder claims the available frame
//   dec_done          decoder releases the frame it holds
//   rd_en/rd_addr     decoder read request
//   rd_data/rd_data_valid           read data, one cycle after the request
//   bank_state        {state[1], state[0]}, 2 bits per bank
//   ram_address/ram_data_in/ram_data_out/ram_we/ram_cs   per-bank RAM ports
//   ram_rs            RAM select, equals the read-bank pointer
//
// Optional build macro INT_RAM_CTRL_STATS_EN adds frames_loaded,
// frames_decoded (16-bit wrapping counters) and a sticky load_stall flag.
module int_ram_ctrl #(
   parameter int unsigned DATA_WIDTH = 5,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned FRAME_LEN  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic                  dec_frame_avail,
   input  logic                  dec_start,
   input  logic                  dec_done,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic [3:0]            bank_state,
   output logic [ADDR_WIDTH-1:0] ram_address  [0:1],
   output logic [DATA_WIDTH-1:0] ram_data_in  [0:1],
   input  logic [DATA_WIDTH-1:0] ram_data_out [0:1],
   output logic                  ram_we       [0:1],
   output logic                  ram_cs       [0:1],
   output logic                  ram_rs
`ifdef INT_RAM_CTRL_STATS_EN
   ,
   output logic [15:0]           frames_loaded,
   output logic [15:0]           frames_decoded,
   output logic                  load_stall
`endif
);

   localparam logic [1:0] EMPTY    = 2'b00;
   localparam logic [1:0] FILLING  = 2'b01;
   localparam logic [1:0] FULL     = 2'b10;
   localparam logic [1:0] DECODING = 2'b11;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

   logic [1:0]            state_q [0:1];
   logic [1:0]            state_d [0:1];
   logic                  wr_bank_q, rd_bank_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic                  rd_valid_q;
   logic                  rd_sel_q;   // bank the in-flight read was issued to

   logic [1:0] wr_state, rd_state;
   logic       ld_fire, last_word, start_ok, done_ok, rd_ok;

   assign wr_state = state_q[wr_bank_q];
   assign rd_state = state_q[rd_bank_q];

   // Writable only while EMPTY or FILLING: never overwrite FULL/DECODING.
   assign ld_ready        = (wr_state == EMPTY) || (wr_state == FILLING);
   assign ld_fire         = ld_valid && ld_ready;
   assign last_word       = (wr_addr_q == LAST_ADDR);
   assign dec_frame_avail = (rd_state == FULL);
   assign start_ok        = dec_start && dec_frame_avail;
   assign done_ok         = dec_done && (rd_state == DECODING);
   assign rd_ok           = rd_en && (rd_state == DECODING);

   assign bank_state    = {state_q[1], state_q[0]};
   assign ram_rs        = rd_bank_q;
   assign rd_data_valid = rd_valid_q;
   // Synchronous RAM: data of the bank addressed last cycle appears now.
   assign rd_data       = ram_data_out[rd_sel_q];

   // Load and decode events only ever target disjoint states, so they can
   // apply in the same cycle even when both pointers name the same bank.
   always_comb begin
      state_d[0] = state_q[0];
      state_d[1] = state_q[1];
      if (ld_fire) begin
         state_d[wr_bank_q] = last_word ? FULL : FILLING;
      end
      if (start_ok) begin
         state_d[rd_bank_q] = DECODING;
      end
      if (done_ok) begin
         state_d[rd_bank_q] = EMPTY;
      end
   end

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         ram_cs[b]      = 1'b0;
         ram_we[b]      = 1'b0;
         ram_address[b] = '0;
         ram_data_in[b] = '0;
         if (ld_fire && (wr_bank_q == 1'(b))) begin
            ram_cs[b]      = 1'b1;
            ram_we[b]      = 1'b1;
            ram_address[b] = wr_addr_q;
            ram_data_in[b] = ld_data;
         end else if (rd_ok && (rd_bank_q == 1'(b))) begin
            ram_cs[b]      = 1'b1;
            ram_address[b] = rd_addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q[0] <= EMPTY;
         state_q[1] <= EMPTY;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_addr_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_sel_q   <= 1'b0;
      end else begin
         state_q[0] <= state_d[0];
         state_q[1] <= state_d[1];
         rd_valid_q <= rd_ok;
         rd_sel_q   <= rd_bank_q;
         if (ld_fire) begin
            if (last_word) begin
               wr_addr_q <= '0;
               wr_bank_q <= ~wr_bank_q;
            end else begin
               wr_addr_q <= wr_addr_q + 1'b1;
            end
         end
         if (done_ok) begin
            rd_bank_q <= ~rd_bank_q;
         end
      end
   end

`ifdef INT_RAM_CTRL_STATS_EN
   logic [15:0] frames_loaded_q, frames_decoded_q;
   logic        load_stall_q;

   assign frames_loaded  = frames_loaded_q;
   assign frames_decoded = frames_decoded_q;
   assign load_stall     = load_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frames_loaded_q  <= '0;
         frames_decoded_q <= '0;
         load_stall_q     <= 1'b0;
      end else begin
         if (ld_fire && last_word) begin
            frames_loaded_q <= frames_loaded_q + 16'd1;
         end
         if (done_ok) begin
            frames_decoded_q <= frames_decoded_q + 16'd1;
         end
         if (ld_valid && !ld_ready) begin
            load_stall_q <= 1'b1;
         end
      end
   end
`endif

endmodule
